// File: rtl/pacote_controle_pkg.sv
// Shared types and constants for the writeback sequencer: instruction classes,
// FSM states and result-mux select codes.
package pacote_controle_pkg;

    typedef enum logic [1:0] {
        CL_ULA   = 2'b00,
        CL_LOAD  = 2'b01,
        CL_JAL   = 2'b10,
        CL_STORE = 2'b11
    } classe_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MEM_WAIT,
        WB
    } estado_t;

    localparam logic [1:0] SEL_ULA = 2'b00;
    localparam logic [1:0] SEL_MD  = 2'b01;
    localparam logic [1:0] SEL_PC  = 2'b10;

    // STORE has no result to write back, so it parks the mux on the ULA input.
    function automatic logic [1:0] sel_da_classe(classe_t c);
        case (c)
            CL_LOAD: return SEL_MD;
            CL_JAL:  return SEL_PC;
            default: return SEL_ULA;
        endcase
    endfunction

endpackage

// File: rtl/contador_timeout.sv
// Cycle counter for the MEM_WAIT timeout: synchronous clear, count enable,
// saturates instead of wrapping, flags the last allowed waiting cycle.
module contador_timeout #(
    parameter int TIMEOUT_CICLOS = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = $clog2(TIMEOUT_CICLOS + 1);

    logic [CW-1:0] contagem;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contagem <= '0;
        end else if (clear) begin
            contagem <= '0;
        end else if (enable && (contagem != CW'(TIMEOUT_CICLOS))) begin
            contagem <= contagem + 1'b1;
        end
    end

    assign terminal = (contagem == CW'(TIMEOUT_CICLOS - 1));

endmodule

// File: rtl/sequenciador_writeback.sv
// Writeback sequencer: accepts one decoded instruction per handshake, runs the
// data-memory handshake with timeout and owns the writeback write-enables.
module sequenciador_writeback
    import pacote_controle_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 15,
    parameter int REG_ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [1:0]            instr_classe,
    input  logic [REG_ADDR_W-1:0] instr_rd,
    output logic                  md_req,
    output logic                  md_we,
    input  logic                  md_ack,
    output logic [1:0]            sel_resultado,
    output logic                  br_we,
    output logic [REG_ADDR_W-1:0] br_end,
    output logic                  pc_we,
    output logic                  erro_timeout
);

    estado_t estado;
    classe_t classe;
    classe_t classe_nova;
    logic    transfer;
    logic    fim_espera;

    assign classe_nova = classe_t'(instr_classe);
    assign transfer    = instr_valid & instr_ready;

    contador_timeout #(.TIMEOUT_CICLOS(TIMEOUT_CICLOS)) u_contador (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (transfer),
        .enable   (estado == MEM_WAIT),
        .terminal (fim_espera)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado        <= IDLE;
            classe        <= CL_ULA;
            instr_ready   <= 1'b1;
            md_req        <= 1'b0;
            md_we         <= 1'b0;
            sel_resultado <= SEL_ULA;
            br_we         <= 1'b0;
            br_end        <= '0;
            pc_we         <= 1'b0;
            erro_timeout  <= 1'b0;
        end else begin
            // Write enables and the error flag are single-cycle pulses.
            br_we        <= 1'b0;
            pc_we        <= 1'b0;
            erro_timeout <= 1'b0;

            case (estado)
                IDLE: begin
                    if (transfer) begin
                        classe        <= classe_nova;
                        br_end        <= instr_rd;
                        sel_resultado <= sel_da_classe(classe_nova);
                        instr_ready   <= 1'b0;
                        case (classe_nova)
                            CL_ULA: estado <= EXEC;
                            CL_JAL: begin
                                estado <= WB;
                                br_we  <= 1'b1;
                                pc_we  <= 1'b1;
                            end
                            CL_LOAD, CL_STORE: begin
                                estado <= MEM_WAIT;
                                md_req <= 1'b1;
                                md_we  <= (classe_nova == CL_STORE);
                            end
                        endcase
                    end
                end

                EXEC: begin
                    estado <= WB;
                    br_we  <= 1'b1;
                    pc_we  <= 1'b1;
                end

                // An ack on the last allowed cycle still completes the access.
                MEM_WAIT: begin
                    if (md_ack) begin
                        estado <= WB;
                        md_req <= 1'b0;
                        md_we  <= 1'b0;
                        br_we  <= (classe != CL_STORE);
                        pc_we  <= 1'b1;
                    end else if (fim_espera) begin
                        estado       <= IDLE;
                        md_req       <= 1'b0;
                        md_we        <= 1'b0;
                        pc_we        <= 1'b1;
                        erro_timeout <= 1'b1;
                        instr_ready  <= 1'b1;
                    end
                end

                WB: begin
                    estado      <= IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequenciador_writeback.sv
// Self-checking bench for sequenciador_writeback: directed scenarios plus
// randomized instruction streams against a per-cycle transaction model.
module tb_sequenciador_writeback;

    localparam int T  = 4;
    localparam int RW = 3;

    logic          clk;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [1:0]    instr_classe;
    logic [RW-1:0] instr_rd;
    logic          md_req;
    logic          md_we;
    logic          md_ack;
    logic [1:0]    sel_resultado;
    logic          br_we;
    logic [RW-1:0] br_end;
    logic          pc_we;
    logic          erro_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]    last_sel = 2'b00;
    logic [RW-1:0] last_rd  = '0;

    sequenciador_writeback #(.TIMEOUT_CICLOS(T), .REG_ADDR_W(RW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_classe  (instr_classe),
        .instr_rd      (instr_rd),
        .md_req        (md_req),
        .md_we         (md_we),
        .md_ack        (md_ack),
        .sel_resultado (sel_resultado),
        .br_we         (br_we),
        .br_end        (br_end),
        .pc_we         (pc_we),
        .erro_timeout  (erro_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: ready, req, we, sel[1:0], br_we, br_end[2:0], pc_we, erro.
    function automatic logic [10:0] observed();
        return {instr_ready, md_req, md_we, sel_resultado, br_we, br_end, pc_we, erro_timeout};
    endfunction

    function automatic logic [1:0] sel_of(logic [1:0] cls);
        return (cls == 2'd1) ? 2'b01 : (cls == 2'd2) ? 2'b10 : 2'b00;
    endfunction

    // Cycles from the transfer edge to the last busy cycle (WB, or the abort cycle).
    function automatic int latency(logic [1:0] cls, int n_ack);
        if (cls == 2'd0) return 2;
        if (cls == 2'd2) return 1;
        return (n_ack == 0) ? T + 1 : n_ack + 1;
    endfunction

    // Expected outputs k cycles after the transfer; n_ack=0 means the memory never answers.
    function automatic logic [10:0] expected_at(logic [1:0] cls, logic [RW-1:0] rd, int n_ack, int k);
        logic mem, timeout, wb, abort, memwait, ready;
        int   lat;
        mem     = (cls == 2'd1) || (cls == 2'd3);
        timeout = mem && (n_ack == 0);
        lat     = latency(cls, n_ack);
        wb      = !timeout && (k == lat);
        abort   = timeout && (k == lat);
        memwait = mem && (k < lat);
        ready   = timeout ? (k >= lat) : (k > lat);
        return {ready, memwait, memwait && (cls == 2'd3), sel_of(cls),
                wb && (cls != 2'd3), rd, wb || abort, abort};
    endfunction

    // Called just after a falling edge with the DUT idle; returns just after a falling edge.
    task automatic exercise(input logic [1:0] cls, input logic [RW-1:0] rd, input int n_ack);
        int         lat;
        logic [10:0] exp_v, obs_v;
        lat          = latency(cls, n_ack);
        instr_valid  = 1'b1;
        instr_classe = cls;
        instr_rd     = rd;
        md_ack       = 1'($urandom % 2);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            exp_v = expected_at(cls, rd, n_ack, k);
            obs_v = observed();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle cls=%0d rd=%0d ack_at=%0d k=%0d: got rdy,req,we,sel,br,end,pc,err=%b expected %b",
                         cls, rd, n_ack, k, obs_v, exp_v);
            end
            if (exp_v[10]) begin
                instr_valid = 1'b0;
            end else begin
                instr_valid  = 1'b1;
                instr_classe = 2'($urandom % 4);
                instr_rd     = RW'($urandom % 8);
            end
            md_ack = exp_v[9] ? (k == n_ack) : 1'($urandom % 2);
        end
        last_sel = sel_of(cls);
        last_rd  = rd;
    endtask

    task automatic idle_cycles(input int n);
        logic [10:0] exp_v;
        for (int i = 0; i < n; i++) begin
            instr_valid = 1'b0;
            md_ack      = 1'($urandom % 2);
            @(negedge clk);
            exp_v = {1'b1, 1'b0, 1'b0, last_sel, 1'b0, last_rd, 1'b0, 1'b0};
            n_checks++;
            if (observed() !== exp_v) begin
                n_fail++;
                $display("FAIL idle: got %b expected %b", observed(), exp_v);
            end
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        instr_valid  = 1'b0;
        instr_classe = 2'b00;
        instr_rd     = '0;
        md_ack       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (observed() !== 11'b1_0_0_00_0_000_0_0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected %b", observed(), 11'b1_0_0_00_0_000_0_0);
        end
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_alu();
        exercise(2'd0, 3'd5, 0);
    endtask

    task automatic test_load();
        exercise(2'd1, 3'd2, 3);
    endtask

    task automatic test_store();
        exercise(2'd3, 3'd6, 1);
    endtask

    task automatic test_jal();
        exercise(2'd2, 3'd7, 0);
        idle_cycles(3);
    endtask

    task automatic test_timeout();
        exercise(2'd1, 3'd3, 0);
        idle_cycles(1);
        exercise(2'd1, 3'd1, T);
        exercise(2'd3, 3'd4, 0);
    endtask

    task automatic test_back_to_back();
        exercise(2'd0, 3'd1, 0);
        exercise(2'd2, 3'd2, 0);
        exercise(2'd3, 3'd3, 2);
        exercise(2'd1, 3'd4, 1);
        exercise(2'd0, 3'd0, 0);
    endtask

    task automatic test_random();
        logic [1:0]    cls;
        logic [RW-1:0] rd;
        int            n_ack;
        for (int i = 0; i < 60; i++) begin
            cls   = 2'($urandom % 4);
            rd    = RW'($urandom % 8);
            n_ack = (cls == 2'd1 || cls == 2'd3) ? int'($urandom_range(0, T)) : 0;
            exercise(cls, rd, n_ack);
            idle_cycles(int'($urandom % 3));
        end
    endtask

    task automatic test_reset_mid_mem();
        instr_valid  = 1'b1;
        instr_classe = 2'd1;
        instr_rd     = 3'd4;
        md_ack       = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        n_checks++;
        if (md_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_mem_req: got %b expected 1", md_req);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (observed() !== 11'b1_0_0_00_0_000_0_0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected %b", observed(), 11'b1_0_0_00_0_000_0_0);
        end
        md_ack = 1'b1;
        @(negedge clk);
        rst_n    = 1'b1;
        last_sel = 2'b00;
        last_rd  = '0;
        idle_cycles(5);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_jal();
        test_timeout();
        test_back_to_back();
        test_reset_mid_mem();
        test_random();
        exercise(2'd2, 3'd5, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
